// File: rtl/etapa_memoria_if.sv
// Handshake and data bundle between the ALU stage, the memory-access stage
// and the register-file write stage.
//   master : upstream/downstream side (drives request, observes response)
//   slave  : the memory-access stage (observes request, drives response)
//   Direccion/DatoEscritura/MemRead/MemWrite/Valido_in : request
//   Listo                                               : stage can accept
//   Resultado/Valido_out/Error/EsCarga                  : write-back response
interface etapa_memoria_if #(
    parameter int ANCHO = 32
);
    logic [ANCHO-1:0] Direccion;
    logic [ANCHO-1:0] DatoEscritura;
    logic             MemRead;
    logic             MemWrite;
    logic             Valido_in;
    logic             Listo;
    logic [ANCHO-1:0] Resultado;
    logic             Valido_out;
    logic             Error;
    logic             EsCarga;

    modport master (
        output Direccion, DatoEscritura, MemRead, MemWrite, Valido_in,
        input  Listo, Resultado, Valido_out, Error, EsCarga
    );

    modport slave (
        input  Direccion, DatoEscritura, MemRead, MemWrite, Valido_in,
        output Listo, Resultado, Valido_out, Error, EsCarga
    );
endinterface

// File: rtl/etapa_memoria.sv
// Memory-access stage behind the ALU. Each accepted request is either a word
// load, a word store into a PROFUNDIDAD x ANCHO data RAM, or a pass-through of
// the ALU result. The write-back value returns two cycles after acceptance
// with a one-cycle Valido_out pulse.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : etapa_memoria_if slave (request in, write-back response out)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// LIBRE     | idle, Listo=1, captures a request on Valido_in
// ACCESO    | decodes captured request; RAM write / read on exiting edge
// RESPUESTA | Valido_out=1 for one cycle, then back to LIBRE
module etapa_memoria #(
    parameter int PROFUNDIDAD = 64,
    parameter int ANCHO       = 32
) (
    input logic           clk,
    input logic           rst_n,
    etapa_memoria_if.slave bus
);

    localparam int IDX_W = $clog2(PROFUNDIDAD);

    localparam logic [1:0] LIBRE     = 2'd0;
    localparam logic [1:0] ACCESO    = 2'd1;
    localparam logic [1:0] RESPUESTA = 2'd2;

    logic [1:0]       estado_q, estado_d;
    logic [ANCHO-1:0] dir_q, dir_d;
    logic [ANCHO-1:0] dato_q, dato_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [ANCHO-1:0] resultado_q, resultado_d;
    logic             error_q, error_d;
    logic             es_carga_q, es_carga_d;

    logic [ANCHO-1:0] mem [PROFUNDIDAD];

    logic [IDX_W-1:0] indice;
    logic             falla;
    logic             escribir;

    assign indice = dir_q[IDX_W+1:2];
    // Range check is on the full address so upper bits cannot alias into RAM.
    assign falla  = (dir_q[1:0] != 2'b00) ||
                    (dir_q >= ANCHO'(4 * PROFUNDIDAD)) ||
                    (mem_read_q && mem_write_q);

    always_comb begin
        estado_d    = estado_q;
        dir_d       = dir_q;
        dato_d      = dato_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        resultado_d = resultado_q;
        error_d     = error_q;
        es_carga_d  = es_carga_q;
        escribir    = 1'b0;

        case (estado_q)
            LIBRE: begin
                if (bus.Valido_in) begin
                    dir_d       = bus.Direccion;
                    dato_d      = bus.DatoEscritura;
                    mem_read_d  = bus.MemRead;
                    mem_write_d = bus.MemWrite;
                    estado_d    = ACCESO;
                end
            end
            ACCESO: begin
                estado_d = RESPUESTA;
                if (!mem_read_q && !mem_write_q) begin
                    resultado_d = dir_q;
                    error_d     = 1'b0;
                    es_carga_d  = 1'b0;
                end else if (falla) begin
                    resultado_d = '0;
                    error_d     = 1'b1;
                    es_carga_d  = mem_read_q;
                end else if (mem_read_q) begin
                    resultado_d = mem[indice];
                    error_d     = 1'b0;
                    es_carga_d  = 1'b1;
                end else begin
                    escribir    = 1'b1;
                    resultado_d = dir_q;
                    error_d     = 1'b0;
                    es_carga_d  = 1'b0;
                end
            end
            RESPUESTA: begin
                estado_d = LIBRE;
            end
            default: begin
                estado_d = LIBRE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= LIBRE;
            dir_q       <= '0;
            dato_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            resultado_q <= '0;
            error_q     <= 1'b0;
            es_carga_q  <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            dir_q       <= dir_d;
            dato_q      <= dato_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            resultado_q <= resultado_d;
            error_q     <= error_d;
            es_carga_q  <= es_carga_d;
        end
    end

    // RAM has no reset; an asserted rst_n forces LIBRE, which blocks the write.
    always_ff @(posedge clk) begin
        if (escribir) begin
            mem[indice] <= dato_q;
        end
    end

    // Decoded straight from state so reset clears Valido_out asynchronously.
    assign bus.Listo      = (estado_q == LIBRE);
    assign bus.Valido_out = (estado_q == RESPUESTA);
    assign bus.Resultado  = resultado_q;
    assign bus.Error      = error_q;
    assign bus.EsCarga    = es_carga_q;

endmodule

// File: tb/tb_etapa_memoria.sv
// Directed bench for etapa_memoria: loads, stores, pass-through, faults,
// back-to-back handshake timing and reset behaviour.
module tb_etapa_memoria;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    etapa_memoria_if #(.ANCHO(32)) bus ();

    etapa_memoria #(
        .PROFUNDIDAD(64),
        .ANCHO      (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_listo(input string tag);
        int n;
        n = 0;
        while (!bus.Listo && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.Listo) check({tag, "_listo_timeout"}, 32'(bus.Listo), 32'd1);
    endtask

    // One request: accept at edge N, check ACCESO at N+1, response at N+2,
    // return to idle with held outputs at N+3.
    task automatic req(input string tag, input logic [31:0] dir, input logic [31:0] dato,
                       input logic rd, input logic wr, input logic [31:0] exp_res,
                       input logic exp_err, input logic exp_carga);
        @(negedge clk);
        bus.Direccion     = dir;
        bus.DatoEscritura = dato;
        bus.MemRead       = rd;
        bus.MemWrite      = wr;
        bus.Valido_in     = 1'b1;
        wait_listo(tag);
        @(posedge clk);
        #1;
        bus.Valido_in = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Direccion = 32'hFFFF_FFFF;
        @(negedge clk);
        check({tag, "_n1_vo"},    32'(bus.Valido_out), 32'd0);
        check({tag, "_n1_listo"}, 32'(bus.Listo),      32'd0);
        @(negedge clk);
        check({tag, "_vo"},    32'(bus.Valido_out), 32'd1);
        check({tag, "_listo"}, 32'(bus.Listo),      32'd0);
        check({tag, "_res"},   bus.Resultado,       exp_res);
        check({tag, "_err"},   32'(bus.Error),      32'(exp_err));
        check({tag, "_carga"}, 32'(bus.EsCarga),    32'(exp_carga));
        @(negedge clk);
        check({tag, "_n3_vo"},    32'(bus.Valido_out), 32'd0);
        check({tag, "_n3_listo"}, 32'(bus.Listo),      32'd1);
        check({tag, "_n3_hold"},  bus.Resultado,       exp_res);
    endtask

    initial begin
        int pulsos;
        checks = 0;
        errors = 0;
        rst_n             = 1'b0;
        bus.Direccion     = '0;
        bus.DatoEscritura = '0;
        bus.MemRead       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.Valido_in     = 1'b0;
        #12;
        check("rst_listo", 32'(bus.Listo),      32'd1);
        check("rst_vo",    32'(bus.Valido_out), 32'd0);
        check("rst_err",   32'(bus.Error),      32'd0);
        check("rst_carga", 32'(bus.EsCarga),    32'd0);
        check("rst_res",   bus.Resultado,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        req("st10",  32'h10,   32'hDEAD_BEEF, 1'b0, 1'b1, 32'h10,        1'b0, 1'b0);
        req("ld10",  32'h10,   32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        req("pass",  32'h1234, 32'h0,         1'b0, 1'b0, 32'h1234,      1'b0, 1'b0);
        req("ld1234",32'h1234, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1);

        req("st0",   32'h0,    32'h0000_AAAA, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0);
        req("st4",   32'h4,    32'h4444_4444, 1'b0, 1'b1, 32'h4,         1'b0, 1'b0);
        req("ld6",   32'h6,    32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1);
        req("ld4a",  32'h4,    32'h0,         1'b1, 1'b0, 32'h4444_4444, 1'b0, 1'b1);
        req("st100", 32'h100,  32'h9999_9999, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
        req("st104", 32'h104,  32'h8888_8888, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0);
        req("ld0a",  32'h0,    32'h0,         1'b1, 1'b0, 32'h0000_AAAA, 1'b0, 1'b1);
        req("ld4b",  32'h4,    32'h0,         1'b1, 1'b0, 32'h4444_4444, 1'b0, 1'b1);
        req("rdwr4", 32'h4,    32'h5555_5555, 1'b1, 1'b1, 32'h0,         1'b1, 1'b1);
        req("ld4c",  32'h4,    32'h0,         1'b1, 1'b0, 32'h4444_4444, 1'b0, 1'b1);

        // Back-to-back with Valido_in held high: accepts every 3 cycles.
        @(negedge clk);
        bus.Direccion = 32'h300;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Valido_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b%0d_listo", k), 32'(bus.Listo), 32'd1);
            @(posedge clk);
            #1;
            if (k < 2) bus.Direccion = 32'h300 + 32'(k + 1);
            else       bus.Valido_in = 1'b0;
            @(negedge clk);
            check($sformatf("b2b%0d_n1_listo", k), 32'(bus.Listo),      32'd0);
            @(negedge clk);
            check($sformatf("b2b%0d_n2_listo", k), 32'(bus.Listo),      32'd0);
            check($sformatf("b2b%0d_vo", k),       32'(bus.Valido_out), 32'd1);
            check($sformatf("b2b%0d_res", k),      bus.Resultado,       32'h300 + 32'(k));
            @(negedge clk);
        end
        pulsos = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.Valido_out) pulsos++;
            @(negedge clk);
        end
        check("b2b_extra_pulses", 32'(pulsos), 32'd0);

        req("stfc",  32'hFC,   32'hA5A5_A5A5, 1'b0, 1'b1, 32'hFC,        1'b0, 1'b0);
        req("ldfc",  32'hFC,   32'h0,         1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b1);
        req("ld0b",  32'h0,    32'h0,         1'b1, 1'b0, 32'h0000_AAAA, 1'b0, 1'b1);
        req("ld100", 32'h100,  32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b1);

        // Reset during ACCESO aborts the store.
        req("st20",  32'h20,   32'h2222_2222, 1'b0, 1'b1, 32'h20,        1'b0, 1'b0);
        @(negedge clk);
        bus.Direccion     = 32'h20;
        bus.DatoEscritura = 32'h1111_1111;
        bus.MemWrite      = 1'b1;
        bus.Valido_in     = 1'b1;
        wait_listo("abort");
        @(posedge clk);
        #1;
        bus.Valido_in = 1'b0;
        bus.MemWrite  = 1'b0;
        check("abort_in_acceso", 32'(bus.Listo), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_listo", 32'(bus.Listo),      32'd1);
        check("abort_vo",    32'(bus.Valido_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulsos = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.Valido_out) pulsos++;
            @(negedge clk);
        end
        check("abort_no_pulse", 32'(pulsos), 32'd0);
        req("ld20",  32'h20,   32'h0,         1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b1);

        // Reset during RESPUESTA drops Valido_out without a clock edge.
        @(negedge clk);
        bus.Direccion = 32'h77;
        bus.Valido_in = 1'b1;
        wait_listo("resp");
        @(posedge clk);
        #1;
        bus.Valido_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("resp_vo_before", 32'(bus.Valido_out), 32'd1);
        check("resp_res_before", bus.Resultado,      32'h77);
        rst_n = 1'b0;
        #1;
        check("resp_vo_after",  32'(bus.Valido_out), 32'd0);
        check("resp_res_after", bus.Resultado,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // RAM contents survive reset.
        req("ld10b", 32'h10,   32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
